idiv: RTL
=========

# idiv

Iterative integer divider for the integer execution cluster, the inverse-operation companion of the pipelined multiplier. It accepts one divide/remainder op at a time from the ALU issue slot and runs a radix-2 restoring loop. It returns a 65-bit result plus the 6-bit flag vector in the same format the multiplier drives. `busy` stalls issue and `alt` gives the scheduler one cycle of early warning of the writeback.

## Interface
- No parameters; widths are fixed by the integer datapath.
- `clk` input 1: the only clock.
- `rst` input 1: synchronous, active-high reset.
- `clkEn` input 1: global stall; when low, all state, including outputs, holds.
- `op_prev` input 13: op code; only bits [7:0] are decoded.
- `en` input 1: issue strobe, sampled with `op_prev`, `R` and `C`.
- `R` input 65: dividend; bit 64 is the pointer tag and is ignored.
- `C` input 65: divisor; bit 64 is ignored.
- `busy` output 1: an op is in flight; `en` is ignored while high.
- `alt` output 1: one-cycle pulse, one cycle before `done`.
- `done` output 1: `Res` and `flg` are valid.
- `Res` output 65: result; bit 64 is always 0.
- `flg` output 6: {C, O, 0, S, Z, P}.

## Operation
- **Accept.** An op is accepted when `clkEn & en & ~busy`. Accepted ops are `op_div64`, `op_idiv64`, `op_div32`, `op_idiv32`, `op_rem64`, `op_irem64`, `op_rem32`, `op_irem32`; any other code is ignored. The accept cycle latches the operands, signedness, width and quotient/remainder select.
- **FSM: IDLE → PREP → ITER → FIX → DONE → IDLE.**
  - PREP: take absolute values for signed ops. 32-bit ops use bits [31:0], sign- or zero-extended. PREP also detects special cases.
  - ITER: N steps, with N=64 for 64-bit ops and N=32 for 32-bit ops. A 7-bit counter counts down to 0.
  - FIX: negate the quotient if the operand signs differ. Negate the remainder if the dividend is negative. Register `Res` and `flg`.
  - DONE: `done`=1 for exactly one clkEn-high cycle.
- **Special cases (PREP → FIX, no ITER):**
  - Divisor zero: quotient = all ones (width-masked), remainder = dividend, C=O=1.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0, O=1, C=0.
- **Result width.** 32-bit ops zero-extend the 32-bit result to `Res[63:0]`; 64-bit ops fill all 64 bits.
- **Flags.** Width-relative, in the multiplier's order.
  - C and O are 0 except in the special cases above.
  - S is the result MSB (bit 31 or bit 63).
  - Z is set when the width-masked result is 0.
  - P = ~^Res[7:0].
- **Reset.** `rst` forces IDLE. `busy`, `alt`, `done`, `Res` and `flg` all go to 0. Reset aborts an in-flight op with no writeback.
- **Back-to-back issue.** `en` in the DONE cycle is accepted, because `busy` is low in DONE.

## Timing
- Count the accept cycle as cycle 0.
- **Normal op:**
  - PREP at cycle 1.
  - ITER at cycles 2..N+1.
  - FIX at cycle N+2; `alt`=1.
  - `done` at cycle N+3: cycle 67 for 64-bit ops, cycle 35 for 32-bit ops.
- **Special case:** FIX at cycle 2 (`alt`=1), `done` at cycle 3.
- `busy` is high from cycle 1 through the FIX cycle.
- **clkEn low:** every register freezes and the cycle count stretches by the number of stalled cycles. `done` or `alt` stays asserted through the stall and drops after the next clkEn-high cycle.
- `Res` and `flg` hold their last value after `done` until the next FIX.

## Structure
- Op codes come from the shared `struct.sv` defines, decoded as `{4'b1000, op_prev[7:0]}`. Add the eight div/rem codes there.
- Put the FSM state enum and the special-case quotient constants in `idiv_pkg`.
- One sub-module, `idiv_step`: combinational, one restoring step. Inputs are the 65-bit partial remainder, the 64-bit divisor and the next dividend bit. Outputs are the new partial remainder and the quotient bit. It is instantiated once and iterated by the FSM.

## Test plan
- `op_div64`, R=100, C=7 → `Res`=14, `flg`={0,0,0,0,0,~^8'h0E}, `done` at cycle 67. Then `op_rem64` with the same operands → `Res`=2.
- `op_idiv32`, R=0xFFFFFFF9 (-7), C=2 → `Res`=0x00000000_FFFFFFFD, S=1, `done` at cycle 35. `op_irem32` with the same operands → `Res`=0x00000000_FFFFFFFF.
- `op_div64`, R=5, C=0 → `Res`=0xFFFF_FFFF_FFFF_FFFF, C=O=1, `alt` at cycle 2, `done` at cycle 3. `op_irem64`, R=0x8000…0, C=-1 → `Res`=0, O=1, Z=1.
- Issue `op_div64`, assert `rst` at cycle 20 → next cycle `busy`=`done`=`alt`=0 and `Res`=0. A new op issued right after completes normally.
- `op_div32` with clkEn low for 5 cycles mid-ITER → `done` at cycle 40. A second `en` while `busy` is ignored. `en` during the `done` cycle is accepted and completes 35 cycles later.

Source files
------------

// File: rtl/idiv_pkg.sv
// Shared types and constants for the iterative integer divider.
// Holds the div/rem op codes, the FSM state encoding and the special-case quotient patterns.
package idiv_pkg;

    // Div/rem op codes, compared against {4'b1000, op_prev[7:0]}
    localparam logic [11:0] op_div64  = 12'h8C0;
    localparam logic [11:0] op_idiv64 = 12'h8C1;
    localparam logic [11:0] op_div32  = 12'h8C2;
    localparam logic [11:0] op_idiv32 = 12'h8C3;
    localparam logic [11:0] op_rem64  = 12'h8C4;
    localparam logic [11:0] op_irem64 = 12'h8C5;
    localparam logic [11:0] op_rem32  = 12'h8C6;
    localparam logic [11:0] op_irem32 = 12'h8C7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } state_t;

    localparam logic [63:0] QUO_ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] QUO_ONES32 = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] QUO_MIN64  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] QUO_MIN32  = 64'h0000_0000_8000_0000;

    function automatic logic [63:0] width_mask(input logic is_32, input logic [63:0] v);
        return is_32 ? {32'b0, v[31:0]} : v;
    endfunction

endpackage

// File: rtl/idiv_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it does not borrow.
module idiv_step (
    input  logic [64:0] rem,
    input  logic [63:0] dvs,
    input  logic        nb,
    output logic [64:0] rem_next,
    output logic        q
);

    logic [64:0] shifted;
    logic [65:0] diff;
    logic        unused_msb;

    // The partial remainder is always below the divisor, so its MSB is never set
    assign unused_msb = rem[64];
    assign shifted    = {rem[63:0], nb};
    assign diff       = {1'b0, shifted} - {2'b00, dvs};
    assign q          = ~diff[65];
    assign rem_next   = q ? diff[64:0] : shifted;

endmodule

// File: rtl/idiv.sv
// Iterative radix-2 restoring divider for 32/64-bit signed/unsigned div and rem.
// One op in flight; busy stalls issue, alt warns one cycle before done.
module idiv
    import idiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clkEn,
    input  logic [12:0] op_prev,
    input  logic        en,
    input  logic [64:0] R,
    input  logic [64:0] C,
    output logic        busy,
    output logic        alt,
    output logic        done,
    output logic [64:0] Res,
    output logic [5:0]  flg
);

    state_t      state_reg, state_next;
    logic [6:0]  cnt_reg;
    logic [63:0] a_reg, b_reg;
    logic        sgn_reg, w32_reg, rem_sel_reg;
    logic [63:0] dvd_reg, dvs_reg, quo_reg;
    logic [64:0] prem_reg;
    logic        neg_q_reg, neg_r_reg, spec_c_reg, spec_o_reg;
    logic [63:0] res_reg;
    logic [5:0]  flg_reg;

    logic [11:0] op_code;
    logic        op_valid, op_sgn, op_w32, op_rem;
    logic        accept;
    logic        unused_bits;

    assign unused_bits = ^{R[64], C[64], op_prev[12:8]};
    assign op_code     = {4'b1000, op_prev[7:0]};

    always_comb begin
        op_valid = 1'b1;
        op_sgn   = 1'b0;
        op_w32   = 1'b0;
        op_rem   = 1'b0;
        case (op_code)
            op_div64:  ;
            op_idiv64: op_sgn = 1'b1;
            op_div32:  op_w32 = 1'b1;
            op_idiv32: begin op_sgn = 1'b1; op_w32 = 1'b1; end
            op_rem64:  op_rem = 1'b1;
            op_irem64: begin op_sgn = 1'b1; op_rem = 1'b1; end
            op_rem32:  begin op_w32 = 1'b1; op_rem = 1'b1; end
            op_irem32: begin op_sgn = 1'b1; op_w32 = 1'b1; op_rem = 1'b1; end
            default:   op_valid = 1'b0;
        endcase
    end

    assign accept = clkEn & en & op_valid & ((state_reg == ST_IDLE) | (state_reg == ST_DONE));

    // Operand preparation and special-case detection, evaluated during PREP
    logic [63:0] a_ext, b_ext, a_abs, b_abs;
    logic        a_neg, b_neg, div_zero, ovf;

    always_comb begin
        a_ext = w32_reg ? (sgn_reg ? {{32{a_reg[31]}}, a_reg[31:0]} : {32'b0, a_reg[31:0]}) : a_reg;
        b_ext = w32_reg ? (sgn_reg ? {{32{b_reg[31]}}, b_reg[31:0]} : {32'b0, b_reg[31:0]}) : b_reg;
        a_neg = sgn_reg & a_ext[63];
        b_neg = sgn_reg & b_ext[63];
        a_abs = a_neg ? (64'd0 - a_ext) : a_ext;
        b_abs = b_neg ? (64'd0 - b_ext) : b_ext;
        div_zero = (b_ext == 64'd0);
        ovf = sgn_reg & (w32_reg ? ((a_reg[31:0] == 32'h8000_0000) && (b_reg[31:0] == 32'hFFFF_FFFF))
                                 : ((a_reg == QUO_MIN64) && (b_reg == QUO_ONES64)));
    end

    logic [64:0] step_rem;
    logic        step_q;

    idiv_step u_step (
        .rem      (prem_reg),
        .dvs      (dvs_reg),
        .nb       (dvd_reg[63]),
        .rem_next (step_rem),
        .q        (step_q)
    );

    logic [63:0] q_fix, r_fix, res_fix;
    logic [5:0]  flg_fix;

    always_comb begin
        q_fix   = neg_q_reg ? (64'd0 - quo_reg) : quo_reg;
        r_fix   = neg_r_reg ? (64'd0 - prem_reg[63:0]) : prem_reg[63:0];
        res_fix = width_mask(w32_reg, rem_sel_reg ? r_fix : q_fix);
        flg_fix = {spec_c_reg, spec_o_reg, 1'b0,
                   (w32_reg ? res_fix[31] : res_fix[63]),
                   (res_fix == 64'd0),
                   ~^res_fix[7:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else if (clkEn) begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        alt        = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_PREP;
            ST_PREP: begin
                busy       = 1'b1;
                state_next = (div_zero | ovf) ? ST_FIX : ST_ITER;
            end
            ST_ITER: begin
                busy = 1'b1;
                if (cnt_reg == 7'd0) state_next = ST_FIX;
            end
            ST_FIX: begin
                busy       = 1'b1;
                alt        = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = accept ? ST_PREP : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= 7'd0;
            a_reg       <= 64'd0;
            b_reg       <= 64'd0;
            sgn_reg     <= 1'b0;
            w32_reg     <= 1'b0;
            rem_sel_reg <= 1'b0;
            dvd_reg     <= 64'd0;
            dvs_reg     <= 64'd0;
            quo_reg     <= 64'd0;
            prem_reg    <= 65'd0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            spec_c_reg  <= 1'b0;
            spec_o_reg  <= 1'b0;
            res_reg     <= 64'd0;
            flg_reg     <= 6'd0;
        end else if (clkEn) begin
            if (accept) begin
                a_reg       <= R[63:0];
                b_reg       <= C[63:0];
                sgn_reg     <= op_sgn;
                w32_reg     <= op_w32;
                rem_sel_reg <= op_rem;
            end
            case (state_reg)
                ST_PREP: begin
                    dvs_reg <= b_abs;
                    // 32-bit dividends are left-aligned so the MSB-first shift works for both widths
                    dvd_reg <= w32_reg ? {a_abs[31:0], 32'b0} : a_abs;
                    cnt_reg <= w32_reg ? 7'd31 : 7'd63;
                    if (div_zero) begin
                        quo_reg    <= w32_reg ? QUO_ONES32 : QUO_ONES64;
                        prem_reg   <= {1'b0, width_mask(w32_reg, a_ext)};
                        neg_q_reg  <= 1'b0;
                        neg_r_reg  <= 1'b0;
                        spec_c_reg <= 1'b1;
                        spec_o_reg <= 1'b1;
                    end else if (ovf) begin
                        quo_reg    <= w32_reg ? QUO_MIN32 : QUO_MIN64;
                        prem_reg   <= 65'd0;
                        neg_q_reg  <= 1'b0;
                        neg_r_reg  <= 1'b0;
                        spec_c_reg <= 1'b0;
                        spec_o_reg <= 1'b1;
                    end else begin
                        quo_reg    <= 64'd0;
                        prem_reg   <= 65'd0;
                        neg_q_reg  <= a_neg ^ b_neg;
                        neg_r_reg  <= a_neg;
                        spec_c_reg <= 1'b0;
                        spec_o_reg <= 1'b0;
                    end
                end
                ST_ITER: begin
                    prem_reg <= step_rem;
                    quo_reg  <= {quo_reg[62:0], step_q};
                    dvd_reg  <= {dvd_reg[62:0], 1'b0};
                    cnt_reg  <= cnt_reg - 7'd1;
                end
                ST_FIX: begin
                    res_reg <= res_fix;
                    flg_reg <= flg_fix;
                end
                default: ;
            endcase
        end
    end

    assign Res = {1'b0, res_reg};
    assign flg = flg_reg;

endmodule
